// File: rtl/vehicle_queue_sensor_if.sv
// Loop-detector inputs and queue-occupancy outputs for the four approaches.
// The master drives the raw loops; the slave (the sensor) drives the occupancy view.
interface vehicle_queue_sensor_if #(
   parameter int unsigned CNT_W = 4
);
   logic             arr_NS, arr_SN, arr_EW, arr_WE;
   logic             dep_NS, dep_SN, dep_EW, dep_WE;
   logic             S1_NS, S1_SN, S1_EW, S1_WE;
   logic             S5_NS, S5_SN, S5_EW, S5_WE;
   logic [CNT_W-1:0] q_NS, q_SN, q_EW, q_WE;
   logic [3:0]       ovf;

   modport master (
      output arr_NS, arr_SN, arr_EW, arr_WE,
      output dep_NS, dep_SN, dep_EW, dep_WE,
      input  S1_NS, S1_SN, S1_EW, S1_WE,
      input  S5_NS, S5_SN, S5_EW, S5_WE,
      input  q_NS, q_SN, q_EW, q_WE,
      input  ovf
   );

   modport slave (
      input  arr_NS, arr_SN, arr_EW, arr_WE,
      input  dep_NS, dep_SN, dep_EW, dep_WE,
      output S1_NS, S1_SN, S1_EW, S1_WE,
      output S5_NS, S5_SN, S5_EW, S5_WE,
      output q_NS, q_SN, q_EW, q_WE,
      output ovf
   );
endinterface

// File: rtl/vehicle_queue_sensor.sv
// Per-approach queue sensor: sync + debounce + rising-edge detect on 8 loops,
// saturating queue counters and registered light/heavy occupancy flags.
module vehicle_queue_sensor #(
   parameter int unsigned CNT_W     = 4,
   parameter int unsigned T1        = 1,
   parameter int unsigned T5        = 5,
   parameter int unsigned DB_CYCLES = 3
) (
   input logic                   clk,
   input logic                   rst,
   vehicle_queue_sensor_if.slave bus
);

   localparam int unsigned      DbW    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DbW-1:0]   DbLast = DbW'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] Thr1   = CNT_W'(T1);
   localparam logic [CNT_W-1:0] Thr5   = CNT_W'(T5);

   // Detector index: [3:0] arrival loops, [7:4] stop-line loops, each {WE,EW,SN,NS}.
   logic [7:0] raw;
   logic [7:0] sync1_q, sync_q;
   logic [7:0] deb_q, deb_d, deb_prev_q, pulse_q;
   logic [DbW-1:0] dbc_q [8];
   logic [DbW-1:0] dbc_d [8];

   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [3:0] ovf_q, ovf_d, s1_q, s1_d, s5_q, s5_d;

   assign raw = {bus.dep_WE, bus.dep_EW, bus.dep_SN, bus.dep_NS,
                 bus.arr_WE, bus.arr_EW, bus.arr_SN, bus.arr_NS};

   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 8; i++) begin
         dbc_d[i] = '0;
         if (sync_q[i] != deb_q[i]) begin
            if (dbc_q[i] == DbLast) begin
               deb_d[i] = sync_q[i];
            end else begin
               dbc_d[i] = dbc_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      ovf_d = ovf_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
         case ({pulse_q[i], pulse_q[i+4]})
            2'b10: begin
               if (cnt_q[i] == CntMax) ovf_d[i] = 1'b1;
               else                    cnt_d[i] = cnt_q[i] + 1'b1;
            end
            2'b01: begin
               if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
            end
            default: ;
         endcase
         // Flags follow the next count so they never lag q by a cycle.
         s1_d[i] = (cnt_d[i] >= Thr1);
         s5_d[i] = (cnt_d[i] >= Thr5);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q    <= '0;
         sync_q     <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         pulse_q    <= '0;
         for (int i = 0; i < 8; i++) dbc_q[i] <= '0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
         ovf_q <= '0;
         s1_q  <= '0;
         s5_q  <= '0;
      end else begin
         sync1_q    <= raw;
         sync_q     <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         pulse_q    <= deb_q & ~deb_prev_q;
         for (int i = 0; i < 8; i++) dbc_q[i] <= dbc_d[i];
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
         ovf_q <= ovf_d;
         s1_q  <= s1_d;
         s5_q  <= s5_d;
      end
   end

   assign bus.q_NS  = cnt_q[0];
   assign bus.q_SN  = cnt_q[1];
   assign bus.q_EW  = cnt_q[2];
   assign bus.q_WE  = cnt_q[3];
   assign bus.S1_NS = s1_q[0];
   assign bus.S1_SN = s1_q[1];
   assign bus.S1_EW = s1_q[2];
   assign bus.S1_WE = s1_q[3];
   assign bus.S5_NS = s5_q[0];
   assign bus.S5_SN = s5_q[1];
   assign bus.S5_EW = s5_q[2];
   assign bus.S5_WE = s5_q[3];
   assign bus.ovf   = ovf_q;

endmodule
